// File: rtl/rename_alloc_ctrl.sv
// Rename-stage tag allocator: owns the physical free list, feeds GMT writes,
// sequences post-reset GMT/free-list init and rewinds allocations on flush.
module rename_alloc_ctrl #(
  parameter int ARCH_COUNT      = 32,
  parameter int ARCH_ADDR_WIDTH = $clog2(ARCH_COUNT),
  parameter int PHYS_COUNT      = 64,
  parameter int PHYS_ADDR_WIDTH = $clog2(PHYS_COUNT),
  parameter int RENAME_WIDTH    = 2,
  parameter int FREE_WIDTH      = 2
) (
  input  logic                            clk,
  input  logic                            async_rst,
  input  logic                            clk_en,
  input  logic                            ren_valid,
  output logic                            ren_ready,
  input  logic [RENAME_WIDTH-1:0]         ren_dst_valid,
  input  logic [RENAME_WIDTH-1:0][ARCH_ADDR_WIDTH-1:0] ren_dst_arch,
  output logic                            out_valid,
  output logic [RENAME_WIDTH-1:0][PHYS_ADDR_WIDTH-1:0] out_phys_tag,
  output logic [RENAME_WIDTH-1:0]         map_wr_en,
  output logic [RENAME_WIDTH-1:0][ARCH_ADDR_WIDTH-1:0] map_wr_arch,
  output logic [RENAME_WIDTH-1:0][PHYS_ADDR_WIDTH-1:0] map_wr_phys,
  input  logic [FREE_WIDTH-1:0]           free_valid,
  input  logic [FREE_WIDTH-1:0][PHYS_ADDR_WIDTH-1:0] free_tag,
  input  logic [$clog2(RENAME_WIDTH+1)-1:0] commit_alloc_cnt,
  input  logic                            flush,
  output logic                            init_done,
  output logic [PHYS_ADDR_WIDTH:0]        free_count,
  output logic                            overflow_err
);

  localparam int PW  = PHYS_ADDR_WIDTH;
  localparam int AW  = ARCH_ADDR_WIDTH;
  localparam int PTR = PW + 1;
  localparam logic [PTR-1:0] MAX_OCC  = PTR'(PHYS_COUNT - ARCH_COUNT);
  localparam logic [PW-1:0]  ARCH_LIM = PW'(ARCH_COUNT);
  localparam logic [PW-1:0]  IDX_LAST = PW'(PHYS_COUNT - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t state;

  logic [PW-1:0]  fl_mem [PHYS_COUNT];
  logic [PTR-1:0] tail;
  logic [PTR-1:0] spec_head;
  logic [PTR-1:0] commit_head;
  logic [PW-1:0]  idx;

  logic [PTR-1:0] need_cnt;
  logic [PTR-1:0] commit_nxt;
  logic [PTR-1:0] tail_nxt;
  logic           ovf_hit;
  logic           accept;
  logic [RENAME_WIDTH-1:0]         wr_mask;
  logic [RENAME_WIDTH-1:0][PW-1:0] pop_tag;
  logic [FREE_WIDTH-1:0]           push_en;
  logic [FREE_WIDTH-1:0][PW-1:0]   push_addr;

  assign free_count = tail - spec_head;
  assign commit_nxt = commit_head + PTR'(commit_alloc_cnt);

  always_comb begin
    need_cnt = '0;
    for (int l = 0; l < RENAME_WIDTH; l++)
      need_cnt = need_cnt + PTR'(ren_dst_valid[l]);
  end

  assign ren_ready = clk_en && (state == S_RUN) && !flush &&
                     (free_count >= need_cnt);
  assign accept    = ren_valid && ren_ready;

  // Tags come off spec_head in lane order, skipping lanes without a dest.
  always_comb begin
    logic [PTR-1:0] rd;
    rd = spec_head;
    for (int l = 0; l < RENAME_WIDTH; l++) begin
      pop_tag[l] = '0;
      if (ren_dst_valid[l]) begin
        pop_tag[l] = fl_mem[rd[PW-1:0]];
        rd = rd + 1'b1;
      end
    end
  end

  // Youngest lane wins when several lanes target the same arch reg.
  always_comb begin
    for (int l = 0; l < RENAME_WIDTH; l++) begin
      wr_mask[l] = ren_dst_valid[l];
      for (int h = l + 1; h < RENAME_WIDTH; h++)
        if (ren_dst_valid[h] && (ren_dst_arch[h] == ren_dst_arch[l]))
          wr_mask[l] = 1'b0;
    end
  end

  always_comb begin
    logic [PTR-1:0] t;
    t       = tail;
    ovf_hit = 1'b0;
    for (int f = 0; f < FREE_WIDTH; f++) begin
      push_en[f]   = 1'b0;
      push_addr[f] = t[PW-1:0];
      if (free_valid[f] && (state != S_INIT)) begin
        if ((t - spec_head) == MAX_OCC) begin
          ovf_hit = 1'b1;
        end else begin
          push_en[f] = 1'b1;
          t = t + 1'b1;
        end
      end
    end
    tail_nxt = t;
  end

  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (state == S_INIT) begin
        if (idx >= ARCH_LIM)
          fl_mem[tail[PW-1:0]] <= idx;
      end else begin
        for (int f = 0; f < FREE_WIDTH; f++)
          if (push_en[f])
            fl_mem[push_addr[f]] <= free_tag[f];
      end
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state        <= S_INIT;
      idx          <= '0;
      tail         <= '0;
      spec_head    <= '0;
      commit_head  <= '0;
      out_valid    <= 1'b0;
      out_phys_tag <= '0;
      map_wr_en    <= '0;
      map_wr_arch  <= '0;
      map_wr_phys  <= '0;
      init_done    <= 1'b0;
      overflow_err <= 1'b0;
    end else if (clk_en) begin
      unique case (state)
        S_INIT: begin
          out_valid <= 1'b0;
          map_wr_en <= '0;
          if (idx < ARCH_LIM) begin
            map_wr_en[0]   <= 1'b1;
            map_wr_arch[0] <= idx[AW-1:0];
            map_wr_phys[0] <= idx;
          end else begin
            tail <= tail + 1'b1;
          end
          idx <= idx + 1'b1;
          if (idx == IDX_LAST) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        S_RUN, S_FLUSH: begin
          tail <= tail_nxt;
          if (ovf_hit)
            overflow_err <= 1'b1;
          out_valid <= accept;
          map_wr_en <= accept ? wr_mask : '0;
          if (accept) begin
            out_phys_tag <= pop_tag;
            map_wr_arch  <= ren_dst_arch;
            map_wr_phys  <= pop_tag;
            spec_head    <= spec_head + need_cnt;
          end
          if (state == S_FLUSH) begin
            state <= S_RUN;
          end else if (flush) begin
            state       <= S_FLUSH;
            spec_head   <= commit_nxt;
            commit_head <= commit_nxt;
          end else begin
            commit_head <= commit_nxt;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Directed bench for rename_alloc_ctrl: init sequence, allocation vectors,
// flush rewind, free-list boundaries, overflow and async reset replay.
module tb_rename_alloc_ctrl;

  logic                 clk = 1'b0;
  logic                 async_rst;
  logic                 clk_en;
  logic                 ren_valid;
  logic                 ren_ready;
  logic [1:0]           ren_dst_valid;
  logic [1:0][4:0]      ren_dst_arch;
  logic                 out_valid;
  logic [1:0][5:0]      out_phys_tag;
  logic [1:0]           map_wr_en;
  logic [1:0][4:0]      map_wr_arch;
  logic [1:0][5:0]      map_wr_phys;
  logic [1:0]           free_valid;
  logic [1:0][5:0]      free_tag;
  logic [1:0]           commit_alloc_cnt;
  logic                 flush;
  logic                 init_done;
  logic [6:0]           free_count;
  logic                 overflow_err;

  int checks = 0;
  int errors = 0;

  rename_alloc_ctrl dut (
    .clk              (clk),
    .async_rst        (async_rst),
    .clk_en           (clk_en),
    .ren_valid        (ren_valid),
    .ren_ready        (ren_ready),
    .ren_dst_valid    (ren_dst_valid),
    .ren_dst_arch     (ren_dst_arch),
    .out_valid        (out_valid),
    .out_phys_tag     (out_phys_tag),
    .map_wr_en        (map_wr_en),
    .map_wr_arch      (map_wr_arch),
    .map_wr_phys      (map_wr_phys),
    .free_valid       (free_valid),
    .free_tag         (free_tag),
    .commit_alloc_cnt (commit_alloc_cnt),
    .flush            (flush),
    .init_done        (init_done),
    .free_count       (free_count),
    .overflow_err     (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rv;
    logic [1:0] dv;
    logic [4:0] a0, a1;
    logic [1:0] fv;
    logic [5:0] f0, f1;
    logic [1:0] cc;
    logic       fl;
    logic       e_rdy;
    logic       e_ov;
    logic [5:0] e_t0, e_t1;
    logic [1:0] e_we;
    logic [6:0] e_cnt;
  } vec_t;

  vec_t vt [14];

  function automatic vec_t mk(
    input logic rv, input logic [1:0] dv, input logic [4:0] a0, a1,
    input logic [1:0] fv, input logic [5:0] f0, f1, input logic [1:0] cc,
    input logic fl, input logic e_rdy, input logic e_ov,
    input logic [5:0] e_t0, e_t1, input logic [1:0] e_we,
    input logic [6:0] e_cnt);
    vec_t v;
    v.rv = rv; v.dv = dv; v.a0 = a0; v.a1 = a1;
    v.fv = fv; v.f0 = f0; v.f1 = f1; v.cc = cc; v.fl = fl;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_t0 = e_t0; v.e_t1 = e_t1;
    v.e_we = e_we; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle();
    ren_valid = 1'b0; ren_dst_valid = '0; ren_dst_arch = '0;
    free_valid = '0; free_tag = '0; commit_alloc_cnt = '0; flush = 1'b0;
  endtask

  task automatic do_reset(input bit check);
    async_rst = 1'b1;
    #2;
    if (check) begin
      chk("rst_ready", int'(ren_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_map_wr_en", int'(map_wr_en), 0);
      chk("rst_init_done", int'(init_done), 0);
      chk("rst_overflow", int'(overflow_err), 0);
      chk("rst_free_count", int'(free_count), 0);
    end
    @(negedge clk);
    async_rst = 1'b0;
  endtask

  task automatic run_init();
    int wcnt = 0;
    int bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (map_wr_en[1]) bad++;
      if (map_wr_en[0]) begin
        if (map_wr_arch[0] != 5'(wcnt) || map_wr_phys[0] != 6'(wcnt)) bad++;
        wcnt++;
      end
      if (i == 62) chk("init_done_early", int'(init_done), 0);
    end
    chk("gmt_init_writes", wcnt, 32);
    chk("gmt_init_bad", bad, 0);
    chk("init_done", int'(init_done), 1);
    chk("init_free_count", int'(free_count), 32);
    ren_dst_valid = 2'b11;
    #1;
    chk("init_ready", int'(ren_ready), 1);
    ren_dst_valid = 2'b00;
  endtask

  task automatic apply(input vec_t v, input int i);
    ren_valid = v.rv; ren_dst_valid = v.dv;
    ren_dst_arch[0] = v.a0; ren_dst_arch[1] = v.a1;
    free_valid = v.fv; free_tag[0] = v.f0; free_tag[1] = v.f1;
    commit_alloc_cnt = v.cc; flush = v.fl;
    #1;
    chk($sformatf("v%0d_ready", i), int'(ren_ready), int'(v.e_rdy));
    @(posedge clk); #1;
    idle();
    chk($sformatf("v%0d_out_valid", i), int'(out_valid), int'(v.e_ov));
    chk($sformatf("v%0d_map_wr_en", i), int'(map_wr_en), int'(v.e_we));
    chk($sformatf("v%0d_free_count", i), int'(free_count), int'(v.e_cnt));
    if (v.e_ov) begin
      chk($sformatf("v%0d_tag0", i), int'(out_phys_tag[0]), int'(v.e_t0));
      chk($sformatf("v%0d_tag1", i), int'(out_phys_tag[1]), int'(v.e_t1));
    end
    if (v.e_we[0]) begin
      chk($sformatf("v%0d_wr_arch0", i), int'(map_wr_arch[0]), int'(v.a0));
      chk($sformatf("v%0d_wr_phys0", i), int'(map_wr_phys[0]), int'(v.e_t0));
    end
    if (v.e_we[1]) begin
      chk($sformatf("v%0d_wr_arch1", i), int'(map_wr_arch[1]), int'(v.a1));
      chk($sformatf("v%0d_wr_phys1", i), int'(map_wr_phys[1]), int'(v.e_t1));
    end
  endtask

  initial begin
    //          rv dv     a0 a1 fv    f0  f1 cc fl rdy ov t0  t1  we     cnt
    vt[0]  = mk(1, 2'b11, 3, 5, 2'b00, 0, 0, 0, 0, 1, 1, 32, 33, 2'b11, 30);
    vt[1]  = mk(1, 2'b11, 7, 7, 2'b00, 0, 0, 0, 0, 1, 1, 34, 35, 2'b10, 28);
    vt[2]  = mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0,  0,  2'b00, 28);
    vt[3]  = mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0,  0,  2'b00, 28);
    vt[4]  = mk(1, 2'b01, 9, 0, 2'b00, 0, 0, 0, 0, 1, 1, 36, 0,  2'b01, 27);
    vt[5]  = mk(1, 2'b10, 0, 4, 2'b00, 0, 0, 0, 0, 1, 1, 0,  37, 2'b10, 26);
    vt[6]  = mk(0, 2'b00, 0, 0, 2'b01, 32, 0, 2, 0, 1, 0, 0,  0,  2'b00, 27);
    vt[7]  = mk(1, 2'b11, 1, 2, 2'b00, 0, 0, 1, 1, 0, 0, 0,  0,  2'b00, 30);
    vt[8]  = mk(1, 2'b11, 1, 2, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0,  2'b00, 30);
    vt[9]  = mk(1, 2'b11, 1, 2, 2'b00, 0, 0, 0, 0, 1, 1, 35, 36, 2'b11, 28);
    vt[10] = mk(1, 2'b11, 0, 0, 2'b01, 40, 0, 0, 0, 0, 0, 0,  0,  2'b00, 2);
    vt[11] = mk(1, 2'b11, 10, 11, 2'b00, 0, 0, 0, 0, 1, 1, 32, 40, 2'b11, 0);
    vt[12] = mk(1, 2'b01, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0,  2'b00, 0);
    vt[13] = mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0,  0,  2'b00, 0);

    idle();
    clk_en = 1'b1;
    async_rst = 1'b0;
    #1;
    do_reset(1);
    run_init();
    @(negedge clk);

    for (int i = 0; i <= 9; i++) apply(vt[i], i);

    clk_en = 1'b0;
    ren_valid = 1'b1; ren_dst_valid = 2'b11; free_valid = 2'b01; free_tag[0] = 6'd9;
    @(posedge clk); #1;
    idle();
    chk("hold_free_count", int'(free_count), 28);
    chk("hold_out_valid", int'(out_valid), 1);
    chk("hold_map_wr_en", int'(map_wr_en), 3);
    clk_en = 1'b1;

    for (int i = 0; i < 14; i++) begin
      ren_valid = 1'b1;
      ren_dst_valid = (i == 13) ? 2'b01 : 2'b11;
      @(posedge clk); #1;
    end
    idle();
    chk("fill_free_count", int'(free_count), 1);

    for (int i = 10; i <= 13; i++) apply(vt[i], i);

    do_reset(0);
    run_init();
    free_valid = 2'b01; free_tag[0] = 6'd5;
    @(posedge clk); #1;
    idle();
    chk("ovf_free_count", int'(free_count), 32);
    chk("ovf_err", int'(overflow_err), 1);
    @(posedge clk); #1;
    chk("ovf_sticky", int'(overflow_err), 1);

    do_reset(0);
    for (int i = 0; i < 10; i++) @(posedge clk);
    #1;
    chk("mid_init_arch", int'(map_wr_arch[0]), 9);
    #2;
    async_rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", int'(map_wr_en), 0);
    chk("mid_rst_arch", int'(map_wr_arch[0]), 0);
    chk("mid_rst_init_done", int'(init_done), 0);
    @(negedge clk);
    async_rst = 1'b0;
    @(posedge clk); #1;
    chk("replay_wr_en", int'(map_wr_en), 1);
    chk("replay_arch", int'(map_wr_arch[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
